// File: rtl/idec_pkg.sv
// Shared decode definitions: instruction kinds, ARM condition codes,
// the packed decoded record and the field-decode helper.
package idec_pkg;

  localparam int IDEC_XLEN = 32;
  localparam int IDEC_RW   = 4;

  typedef enum logic [1:0] {
    KIND_NOP = 2'd0,
    KIND_DP  = 2'd1,
    KIND_MEM = 2'd2,
    KIND_BR  = 2'd3
  } kind_e;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [IDEC_RW-1:0] LINK_REG = 4'd14;

  typedef struct packed {
    kind_e                 kind;
    logic [3:0]            alu_op;
    logic                  set_flags;
    logic [IDEC_RW-1:0]    rn;
    logic [IDEC_RW-1:0]    rd;
    logic [IDEC_RW-1:0]    rm;
    logic                  imm_en;
    logic [IDEC_XLEN-1:0]  imm;
    logic                  reg_we;
    logic                  mem_we;
    logic                  mem_re;
    logic                  br_link;
    logic [IDEC_XLEN-1:0]  br_target;
  } dec_rec_t;

  localparam dec_rec_t REC_NONE = '0;

  // Field decode of an instruction assumed to pass its condition.
  function automatic dec_rec_t decode(input logic [31:0] instr, input logic [31:0] pc);
    dec_rec_t    r;
    logic [31:0] imm8;
    logic [63:0] dbl;
    logic [4:0]  sh;
    r    = REC_NONE;
    imm8 = {24'h0, instr[7:0]};
    sh   = {instr[11:8], 1'b0};
    dbl  = {imm8, imm8} >> sh;
    if (instr[27:26] == 2'b00) begin
      r.kind      = KIND_DP;
      r.alu_op    = instr[24:21];
      r.set_flags = instr[20];
      r.rn        = instr[19:16];
      r.rd        = instr[15:12];
      r.rm        = instr[3:0];
      r.imm_en    = instr[25];
      r.imm       = dbl[31:0];
      // opcodes 1000..1011 are the compare family and never write rd
      r.reg_we    = (instr[24:23] != 2'b10);
    end else if (instr[27:26] == 2'b01) begin
      r.kind   = KIND_MEM;
      r.rn     = instr[19:16];
      r.rd     = instr[15:12];
      r.imm_en = ~instr[25];
      r.imm    = {20'h0, instr[11:0]};
      r.mem_re = instr[20];
      r.reg_we = instr[20];
      r.mem_we = ~instr[20];
    end else if (instr[27:25] == 3'b101) begin
      r.kind      = KIND_BR;
      r.br_link   = instr[24];
      r.reg_we    = instr[24];
      r.rd        = instr[24] ? LINK_REG : 4'd0;
      r.br_target = pc + 32'd8 + {{6{instr[23]}}, instr[23:0], 2'b00};
    end
    return r;
  endfunction

endpackage

// File: rtl/idec_cond.sv
// ARM condition-code evaluation: cond field against flags {N,Z,C,V}.
module idec_cond
  import idec_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;
  assign n = flags[3];
  assign z = flags[2];
  assign c = flags[1];
  assign v = flags[0];

  // Condition table; NV never executes.
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/idec_pipe.sv
// One-stage instruction decode pipe with valid/ready handshakes.
// Optional macro IDEC_PIPE_SKID_EN adds a skid entry so in_ready is registered.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds valid and data stable until that edge, and ready may
// not depend on valid. flush_i overrides both sides for that edge.
module idec_pipe
  import idec_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [3:0]        cpsr_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        kind_o,
  output logic [3:0]        alu_op_o,
  output logic              set_flags_o,
  output logic [REG_AW-1:0] rn_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [REG_AW-1:0] rm_o,
  output logic              imm_en_o,
  output logic [XLEN-1:0]   imm_o,
  output logic              reg_we_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic              br_link_o,
  output logic [XLEN-1:0]   br_target_o
);

  logic     cond_pass;
  logic     accept;
  dec_rec_t in_rec;
  dec_rec_t main_q;
  logic     main_v;

  idec_cond u_cond (
    .cond  (instr_i[31:28]),
    .flags (cpsr_i),
    .pass  (cond_pass)
  );

  // A failed condition collapses to an all-zero NOP that still occupies a slot.
  assign in_rec = cond_pass ? decode(instr_i, pc_i) : REC_NONE;
  assign accept = in_valid && in_ready && !flush_i;

`ifdef IDEC_PIPE_SKID_EN
  dec_rec_t skid_q;
  logic     skid_v;

  assign in_ready = !skid_v;

  // Main entry feeds the output; skid catches the one record accepted while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      main_q <= REC_NONE;
      skid_v <= 1'b0;
      skid_q <= REC_NONE;
    end else if (flush_i) begin
      main_v <= 1'b0;
      main_q <= REC_NONE;
      skid_v <= 1'b0;
      skid_q <= REC_NONE;
    end else if (skid_v) begin
      if (out_ready) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (accept) begin
      if (!main_v || out_ready) begin
        main_q <= in_rec;
        main_v <= 1'b1;
      end else begin
        skid_q <= in_rec;
        skid_v <= 1'b1;
      end
    end else if (out_ready) begin
      main_v <= 1'b0;
    end
  end
`else
  assign in_ready = !main_v || out_ready;

  // Single entry: load on accept, empty when drained without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      main_q <= REC_NONE;
    end else if (flush_i) begin
      main_v <= 1'b0;
      main_q <= REC_NONE;
    end else if (accept) begin
      main_q <= in_rec;
      main_v <= 1'b1;
    end else if (out_ready) begin
      main_v <= 1'b0;
    end
  end
`endif

  assign out_valid   = main_v;
  assign kind_o      = main_q.kind;
  assign alu_op_o    = main_q.alu_op;
  assign set_flags_o = main_q.set_flags;
  assign rn_o        = REG_AW'(main_q.rn);
  assign rd_o        = REG_AW'(main_q.rd);
  assign rm_o        = REG_AW'(main_q.rm);
  assign imm_en_o    = main_q.imm_en;
  assign imm_o       = main_q.imm;
  assign reg_we_o    = main_q.reg_we;
  assign mem_we_o    = main_q.mem_we;
  assign mem_re_o    = main_q.mem_re;
  assign br_link_o   = main_q.br_link;
  assign br_target_o = main_q.br_target;

endmodule
